// File: rtl/p4_controller_fsm_if.sv
// Control bundle between the Simple RISC Machine controller and its datapath.
// Start handshake: `s` is sampled only in WAIT (w=1); load_ir also acts only in WAIT, and both on the same edge start the new IR.
interface p4_controller_fsm_if;
  logic [15:0] in;
  logic        load_ir;
  logic        s;
  logic        w;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;

  modport master (
    input  in, load_ir, s,
    output w, sximm5, sximm8, readnum, writenum, shift, ALUop,
           write, loada, loadb, loadc, loads, asel, bsel, vsel
  );

  modport slave (
    output in, load_ir, s,
    input  w, sximm5, sximm8, readnum, writenum, shift, ALUop,
           write, loada, loadb, loadc, loads, asel, bsel, vsel
  );
endinterface

// File: rtl/p4_controller_fsm.sv
// Simple RISC Machine control unit: latches an instruction and sequences the
// datapath one micro-step per clock.
module p4_controller_fsm (
  input  logic                 clk,
  input  logic                 reset_n,
  p4_controller_fsm_if.master  bus,
  output logic [2:0]           state_dbg
);
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (bus.load_ir && (state == S_WAIT)) ir <= bus.in;
    end
  end

  // Raw controls are decoded from state/IR only; reset gating is applied last.
  logic [2:0] nsel;
  logic [2:0] reg_sel;
  logic [1:0] shift_c, aluop_c, vsel_c;
  logic       write_c, loada_c, loadb_c, loadc_c, loads_c, asel_c, bsel_c;

  always_comb begin
    state_next = state;
    nsel       = 3'b000;
    shift_c    = 2'b00;
    aluop_c    = 2'b00;
    vsel_c     = 2'b00;
    write_c    = 1'b0;
    loada_c    = 1'b0;
    loadb_c    = 1'b0;
    loadc_c    = 1'b0;
    loads_c    = 1'b0;
    asel_c     = 1'b0;
    bsel_c     = 1'b0;
    case (state)
      S_WAIT: if (bus.s) state_next = S_DECODE;
      S_DECODE: begin
        if      (opcode == 3'b110 && op == 2'b10) state_next = S_WRITE_IMM;
        else if (opcode == 3'b110 && op == 2'b00) state_next = S_GET_B;
        else if (opcode == 3'b101 && op == 2'b11) state_next = S_GET_B;
        else if (opcode == 3'b101)                state_next = S_GET_A;
        else                                      state_next = S_WAIT;
      end
      S_WRITE_IMM: begin
        nsel       = 3'b001;
        vsel_c     = 2'b01;
        write_c    = 1'b1;
        state_next = S_WAIT;
      end
      S_GET_A: begin
        nsel       = 3'b001;
        loada_c    = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        nsel       = 3'b100;
        loadb_c    = 1'b1;
        state_next = S_ALU;
      end
      S_ALU: begin
        shift_c    = sh;
        state_next = S_WRITE_REG;
        if (opcode == 3'b110) begin
          asel_c  = 1'b1;
          loadc_c = 1'b1;
        end else if (op == 2'b11) begin
          asel_c  = 1'b1;
          aluop_c = 2'b11;
          loadc_c = 1'b1;
        end else if (op == 2'b01) begin
          aluop_c    = 2'b01;
          loads_c    = 1'b1;
          state_next = S_WAIT;
        end else begin
          aluop_c = op;
          loadc_c = 1'b1;
        end
      end
      S_WRITE_REG: begin
        nsel       = 3'b010;
        write_c    = 1'b1;
        state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

  always_comb begin
    reg_sel = 3'b000;
    if (nsel[0]) reg_sel = rn;
    if (nsel[1]) reg_sel = rd;
    if (nsel[2]) reg_sel = rm;
  end

  // Controls are held low during reset so an aborted instruction cannot write.
  assign bus.readnum  = reset_n ? reg_sel : 3'b000;
  assign bus.writenum = reset_n ? reg_sel : 3'b000;
  assign bus.shift    = reset_n ? shift_c : 2'b00;
  assign bus.ALUop    = reset_n ? aluop_c : 2'b00;
  assign bus.vsel     = reset_n ? vsel_c  : 2'b00;
  assign bus.write    = reset_n & write_c;
  assign bus.loada    = reset_n & loada_c;
  assign bus.loadb    = reset_n & loadb_c;
  assign bus.loadc    = reset_n & loadc_c;
  assign bus.loads    = reset_n & loads_c;
  assign bus.asel     = reset_n & asel_c;
  assign bus.bsel     = reset_n & bsel_c;

  assign bus.w      = (state == S_WAIT);
  assign bus.sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign state_dbg  = state;
endmodule

// File: doc/p4_controller_fsm.md
Name: p4_controller_fsm

Overview:
Control unit for the Simple RISC Machine. It latches a 16-bit instruction, decodes it, and sequences the datapath one micro-step per clock: register-file reads and writes, the A/B/C/status loads, and the operand muxes. It is the driver side of the datapath control interface. Its outputs connect one-to-one to the same-named datapath inputs. At top level, datapath_in is tied to datapath_out (register C).

Parameters:
None. The ISA fields and widths are fixed.

Ports:
clk       input   1   rising-edge clock
reset_n   input   1   synchronous, active-low reset
in        input   16  instruction word
load_ir   input   1   load `in` into the instruction register
s         input   1   start execution of the held instruction
w         output  1   idle/waiting; high only in WAIT
sximm5    output  16  sign-extended IR[4:0]
sximm8    output  16  sign-extended IR[7:0]
readnum   output  3   register-file read index
writenum  output  3   register-file write index; always equals readnum
shift     output  2   shifter control
ALUop     output  2   ALU operation
write, loada, loadb, loadc, loads, asel, bsel   output  1 each   datapath controls
vsel      output  2   writeback select: 00 = datapath_in (C), 01 = sximm8

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: state = WAIT, IR = 0, w = 1.
- Reset gating: while reset_n = 0, every control output is forced to 0. This includes write and the loads, so an instruction aborted by reset never writes on the reset edge.
- Instruction fields (from IR):
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0]
- nsel: an internal one-hot selector of Rn/Rd/Rm. readnum and writenum are both driven by the register nsel selects.
- IR loading: IR <= in on a clock edge where load_ir = 1 and state = WAIT. load_ir is ignored in every other state.
- Outputs: all controls are combinational functions of state and IR only. They never depend on s or in.
- Idle value of each control: every control is 0 except in the states listed below.
- States and transitions:
  - WAIT: w = 1. If s = 1, go to DECODE; otherwise stay in WAIT.
  - DECODE: no controls asserted.
    - opcode 110, op 10 (MOV imm): go to WRITE_IMM.
    - opcode 110, op 00 (MOV reg): go to GET_B.
    - opcode 101, op 11 (MVN): go to GET_B.
    - opcode 101, op 00/01/10 (ADD/CMP/AND): go to GET_A.
    - Any other encoding: go to WAIT with no side effects.
  - WRITE_IMM: nsel = Rn, vsel = 01, write = 1. Then go to WAIT.
  - GET_A: nsel = Rn, loada = 1. Then go to GET_B.
  - GET_B: nsel = Rm, loadb = 1. Then go to ALU.
  - ALU: shift = sh, bsel = 0.
    - MOV reg: asel = 1, ALUop = 00, loadc = 1.
    - MVN: asel = 1, ALUop = 11, loadc = 1.
    - ADD/AND: asel = 0, ALUop = op, loadc = 1.
    - CMP: asel = 0, ALUop = 01, loads = 1, loadc = 0, then go to WAIT.
    - All other cases go to WRITE_REG.
  - WRITE_REG: nsel = Rd, vsel = 00, write = 1. Then go to WAIT.
- Latency, counting edges from the edge that samples s = 1 to the return to WAIT:
  - MOV imm: 3
  - MOV reg, MVN: 5
  - ADD, AND, CMP (CMP has no WRITE_REG): 6, 6, 5
  - Illegal encoding: 2
- Boundary conditions:
  - s held high continuously re-executes the same IR. A new start occurs on the first edge back in WAIT.
  - load_ir and s asserted on the same WAIT edge: the new IR is loaded and DECODE uses the new IR.
  - sximm5 and sximm8 are pure functions of IR, valid in all states.
- Data sequencing: the datapath captures loads and writes on the same clk edge that leaves the corresponding state. No extra pipeline stage exists.

Test Plan:
1. Reset with reset_n = 0 while s = 1 mid-ADD:
   - Response: next cycle w = 1; write, loada, loadb, loadc and loads are 0 throughout the reset cycle.
2. MOV imm: load D007, pulse s:
   - Next cycle: DECODE.
   - Following cycle: WRITE_IMM with readnum = writenum = 0, vsel = 01, write = 1, sximm8 = 0007.
   - w = 1 three edges after s.
   - Also load D1FE: sximm8 = FFFE, writenum = 1.
3. ADD R2,R1,R0,LSL#1 (A148):
   - GET_A readnum = 1, loada.
   - GET_B readnum = 0, loadb.
   - ALU: shift = 01, ALUop = 00, asel = 0, loadc.
   - WRITE_REG: writenum = 2, vsel = 00, write.
   - w returns after 6 edges.
4. CMP R0,R1 (A801):
   - ALU state: ALUop = 01, loads = 1, loadc = 0.
   - No write asserted for the whole instruction; 5 edges.
5. MVN R3,R0 (B860):
   - No GET_A state.
   - ALU: asel = 1, ALUop = 11.
   - WRITE_REG: writenum = 3.
   - Also: load_ir with in = 0000 pulsed during GET_B leaves IR = B860.
6. Illegal E000: DECODE goes to WAIT in 2 edges with no control asserted.
